// File: rtl/ctrl_pkg.sv
// Shared types and codes for the accumulator-CPU multi-cycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode table, ALU/accumulator select codes,
// sticky error codes and the decoded control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  // Opcode table (4-bit codes, zero-extended when OPW > 4)
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function selects
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;

  // Accumulator source selects
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_MEM = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  // Sticky error causes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // EXEC-cycle control word produced by the decoder
  typedef struct packed {
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       load_reg;
    logic       sel_pc;
    logic       load_pc;
    logic       mem_op;   // instruction waits on the memory handshake
    logic       mem_we;
    logic       halt;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the slave side stalls the controller.
// master = controller (drives strobes/mem_req), slave = datapath + memory.
interface multicycle_ctrl_if #(
  parameter int OPW  = 4,
  parameter int ALUW = 4
);
  logic            run;
  logic [OPW-1:0]  Opcode;
  logic            zero;
  logic            mem_ready;
  logic            LoadIR;
  logic            IncPC;
  logic            SelPC;
  logic            LoadPC;
  logic            LoadReg;
  logic            LoadAcc;
  logic [1:0]      SelAcc;
  logic [ALUW-1:0] SelALU;
  logic            mem_req;
  logic            mem_we;
  logic            halted;
  logic [1:0]      err;

  modport master (
    input  run, Opcode, zero, mem_ready,
    output LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, mem_req, mem_we, halted, err
  );

  modport slave (
    output run, Opcode, zero, mem_ready,
    input  LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, mem_req, mem_we, halted, err
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps an opcode and the zero flag to an EXEC control word.
// Latency: combinational.
// Backpressure: none.
// Ports: op_i opcode, zero_i accumulator-zero flag, cw_o control word,
// legal_o high for opcodes in the table.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op_i,
  input  logic           zero_i,
  output ctrl_word_t     cw_o,
  output logic           legal_o
);

  always_comb begin
    cw_o    = '0;
    legal_o = 1'b0;
    // Any set bit above the 4-bit table makes the opcode illegal.
    if ((op_i >> 4) == '0) begin
      legal_o = 1'b1;
      case (op_i[3:0])
        OP_NOP:   ;
        OP_LOAD:  begin cw_o.mem_op = 1'b1; cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_MEM; end
        OP_ADD:   begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_ALU; cw_o.sel_alu = ALU_ADD; end
        OP_SUB:   begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_ALU; cw_o.sel_alu = ALU_SUB; end
        OP_AND:   begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_ALU; cw_o.sel_alu = ALU_AND; end
        OP_OR:    begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_ALU; cw_o.sel_alu = ALU_OR;  end
        OP_XOR:   begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_ALU; cw_o.sel_alu = ALU_XOR; end
        OP_LDI:   begin cw_o.load_acc = 1'b1; cw_o.sel_acc = ACC_IMM; end
        OP_MOV:   cw_o.load_reg = 1'b1;
        OP_STORE: begin cw_o.mem_op = 1'b1; cw_o.mem_we = 1'b1; end
        OP_JMP:   begin cw_o.sel_pc = 1'b1; cw_o.load_pc = 1'b1; end
        OP_JZ:    begin cw_o.sel_pc = zero_i; cw_o.load_pc = zero_i; end
        OP_HALT:  cw_o.halt = 1'b1;
        default:  legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the accumulator CPU.
// Latency: 3 cycles per instruction with mem_ready high, plus memory wait cycles.
// Backpressure: mem_req holds until mem_ready; a stuck memory halts after TIMEOUT waits.
// Ports: clk, reset (sync, active-high), bus (master side: run/Opcode/zero/mem_ready
// in; IR/PC/reg/acc/ALU strobes, mem_req/mem_we, sticky halted/err out).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           halted_q, halted_d;
  logic [1:0]     err_q, err_d;

  logic [OPW-1:0] dec_op;
  ctrl_word_t     cw;
  logic           legal;
  logic           timed_out;

  logic       load_ir, inc_pc, sel_pc, load_pc, load_reg, load_acc, mem_req, mem_we;
  logic [1:0] sel_acc;
  logic [3:0] sel_alu;

  // DECODE judges legality on the live opcode; EXEC uses the latched copy.
  assign dec_op = (state_q == ST_DECODE) ? bus.Opcode : op_q;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .op_i    (dec_op),
    .zero_i  (bus.zero),
    .cw_o    (cw),
    .legal_o (legal)
  );

  // Counter already holds TIMEOUT waits: a further unready cycle gives up.
  assign timed_out = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    err_d    = err_q;
    load_ir  = 1'b0;
    inc_pc   = 1'b0;
    sel_pc   = 1'b0;
    load_pc  = 1'b0;
    load_reg = 1'b0;
    load_acc = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    sel_acc  = ACC_ALU;
    sel_alu  = ALU_NONE;

    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          load_ir = 1'b1;
          inc_pc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timed_out) begin
          state_d = ST_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_DECODE: begin
        op_d = bus.Opcode;
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (cw.halt) begin
          state_d = ST_HALT;
        end else if (cw.mem_op && !bus.mem_ready) begin
          mem_req = 1'b1;
          mem_we  = cw.mem_we;
          if (timed_out) begin
            state_d = ST_HALT;
            err_d   = ERR_TIMEOUT;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end else begin
          // Completion cycle: instruction strobes fire once, then run is sampled.
          mem_req  = cw.mem_op;
          mem_we   = cw.mem_we;
          load_acc = cw.load_acc;
          sel_acc  = cw.sel_acc;
          sel_alu  = cw.sel_alu;
          load_reg = cw.load_reg;
          sel_pc   = cw.sel_pc;
          load_pc  = cw.load_pc;
          state_d  = bus.run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_HALT) halted_d = 1'b1;
    // Each new FETCH or EXEC starts its memory wait budget from zero.
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Everything is forced low while reset is asserted, even mid-handshake.
  assign bus.LoadIR  = load_ir  & ~reset;
  assign bus.IncPC   = inc_pc   & ~reset;
  assign bus.SelPC   = sel_pc   & ~reset;
  assign bus.LoadPC  = load_pc  & ~reset;
  assign bus.LoadReg = load_reg & ~reset;
  assign bus.LoadAcc = load_acc & ~reset;
  assign bus.SelAcc  = reset ? 2'b00 : sel_acc;
  assign bus.SelALU  = reset ? '0 : ALUW'(sel_alu);
  assign bus.mem_req = mem_req  & ~reset;
  assign bus.mem_we  = mem_we   & ~reset;
  assign bus.halted  = halted_q & ~reset;
  assign bus.err     = reset ? ERR_NONE : err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level model.
// Latency: n/a.
// Backpressure: memory wait cycles are generated per instruction.
module tb_multicycle_ctrl;

  localparam int OPW     = 4;
  localparam int ALUW    = 4;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic       LoadIR;
    logic       IncPC;
    logic       SelPC;
    logic       LoadPC;
    logic       LoadReg;
    logic       LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
    logic [1:0] err;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPW(OPW), .ALUW(ALUW)) bus ();

  multicycle_ctrl #(.OPW(OPW), .ALUW(ALUW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state at instruction granularity
  logic       m_halted;
  logic [1:0] m_err;
  logic       m_idle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic out_t obs();
    out_t o;
    o.LoadIR  = bus.LoadIR;
    o.IncPC   = bus.IncPC;
    o.SelPC   = bus.SelPC;
    o.LoadPC  = bus.LoadPC;
    o.LoadReg = bus.LoadReg;
    o.LoadAcc = bus.LoadAcc;
    o.SelAcc  = bus.SelAcc;
    o.SelALU  = bus.SelALU;
    o.mem_req = bus.mem_req;
    o.mem_we  = bus.mem_we;
    o.halted  = bus.halted;
    o.err     = bus.err;
    return o;
  endfunction

  function automatic out_t base();
    out_t o = '0;
    o.halted = m_halted;
    o.err    = m_err;
    return o;
  endfunction

  // What the completion cycle of each opcode must show.
  function automatic out_t exec_table(input logic [3:0] op, input logic z);
    out_t o = base();
    case (op)
      4'd1: begin o.LoadAcc = 1; o.SelAcc = 2'b01; o.mem_req = 1; end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin o.LoadAcc = 1; o.SelALU = op - 4'd1; end
      4'd7: begin o.LoadAcc = 1; o.SelAcc = 2'b10; end
      4'd8: o.LoadReg = 1;
      4'd9: begin o.mem_req = 1; o.mem_we = 1; end
      4'd10: begin o.SelPC = 1; o.LoadPC = 1; end
      4'd11: begin o.SelPC = z; o.LoadPC = z; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive inputs (just after posedge), check at negedge, return just after next posedge.
  task automatic cyc(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                     input out_t e, input string tag);
    bus.run       = r;
    bus.Opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    @(negedge clk);
    check_eq(tag, 32'(obs()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_halted = 1'b0;
    m_err    = 2'b00;
    m_idle   = 1'b1;
    cyc(1'b1, 4'($urandom), 1'b1, 1'b1, '0, "reset_cycle");
    cyc(1'b1, 4'($urandom), 1'b1, 1'b1, '0, "reset_cycle");
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), base(), "idle");
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), base(), "halted");
  endtask

  // One instruction: fw/ew = unready memory cycles in FETCH/EXEC,
  // go_on = run value at the completion cycle.
  task automatic run_instr(input logic [3:0] op, input int fw, input int ew,
                           input logic z, input logic go_on);
    out_t e;
    if (m_idle) begin
      cyc(1'b1, op, z, 1'($urandom), base(), "idle_go");
      m_idle = 1'b0;
    end
    for (int i = 0; i < fw; i++) begin
      e = base(); e.mem_req = 1;
      cyc(1'($urandom), op, z, 1'b0, e, "fetch_wait");
      if (i == TIMEOUT) begin m_halted = 1; m_err = 2'b10; return; end
    end
    e = base(); e.mem_req = 1; e.LoadIR = 1; e.IncPC = 1;
    cyc(1'($urandom), op, z, 1'b1, e, "fetch_ready");
    cyc(1'($urandom), op, z, 1'($urandom), base(), "decode");
    if (op >= 4'd12 && op <= 4'd14) begin m_halted = 1; m_err = 2'b01; return; end
    if (op == 4'd15) begin
      cyc(1'($urandom), op, z, 1'($urandom), base(), "exec_halt");
      m_halted = 1;
      return;
    end
    if (op == 4'd1 || op == 4'd9) begin
      for (int i = 0; i < ew; i++) begin
        e = base(); e.mem_req = 1; e.mem_we = (op == 4'd9);
        cyc(1'($urandom), op, z, 1'b0, e, "exec_wait");
        if (i == TIMEOUT) begin m_halted = 1; m_err = 2'b10; return; end
      end
      cyc(go_on, op, z, 1'b1, exec_table(op, z), "exec_mem");
    end else begin
      cyc(go_on, op, z, 1'($urandom), exec_table(op, z), "exec");
    end
    m_idle = !go_on;
  endtask

  initial begin
    logic [3:0] op;
    out_t e;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.Opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    do_reset();
    // ADD then NOP back-to-back, mem_ready high
    run_instr(4'd2, 0, 0, 1'b0, 1'b1);
    run_instr(4'd0, 0, 0, 1'b0, 1'b1);
    // LOAD with three unready EXEC cycles
    run_instr(4'd1, 0, 3, 1'b0, 1'b1);
    // JZ taken and not taken
    run_instr(4'd11, 0, 0, 1'b1, 1'b1);
    run_instr(4'd11, 0, 0, 1'b0, 1'b1);
    // run drops during ADD: completes, then IDLE, then resumes
    run_instr(4'd2, 1, 0, 1'b0, 1'b0);
    idle_cycles(3);
    run_instr(4'd9, 2, 2, 1'b0, 1'b1);
    // ready arriving on the last permitted FETCH cycle
    run_instr(4'd7, TIMEOUT, 0, 1'b0, 1'b1);
    // memory stuck in FETCH
    run_instr(4'd8, TIMEOUT + 1, 0, 1'b0, 1'b1);
    halted_cycles(4);

    do_reset();
    run_instr(4'd12, 0, 0, 1'b0, 1'b1);
    halted_cycles(4);

    do_reset();
    run_instr(4'd10, 0, 0, 1'b0, 1'b1);
    run_instr(4'd15, 0, 0, 1'b0, 1'b1);
    halted_cycles(3);

    do_reset();
    run_instr(4'd9, 0, TIMEOUT, 1'b0, 1'b1);
    run_instr(4'd1, 0, TIMEOUT + 1, 1'b0, 1'b1);
    halted_cycles(2);

    // reset in the middle of a FETCH handshake
    do_reset();
    cyc(1'b1, 4'd2, 1'b0, 1'b0, base(), "idle_go");
    e = base(); e.mem_req = 1;
    cyc(1'b1, 4'd2, 1'b0, 1'b0, e, "fetch_wait");
    do_reset();
    cyc(1'b0, 4'd2, 1'b0, 1'b1, base(), "post_reset_idle");

    // randomized legal traffic
    for (int n = 0; n < 250; n++) begin
      do op = 4'($urandom_range(0, 11)); while (op == 4'd15);
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                ($urandom_range(0, 3) != 0));
      if (m_idle) idle_cycles($urandom_range(0, 2));
    end

    // random tail that may hit illegal/halt/timeout paths
    for (int n = 0; n < 40; n++) begin
      if (m_halted) begin
        halted_cycles(2);
        do_reset();
      end
      run_instr(4'($urandom), $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1),
                1'($urandom), ($urandom_range(0, 3) != 0));
      if (m_idle) idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
